// File: rtl/lab1_imul_arb_pkg.sv
// Shared types and constants for the two-port multiplier arbiter.
// Port ids double as the round-robin pointer and the owner encoding.
package lab1_imul_arb_pkg;

    localparam int REQ_W  = 64;
    localparam int RESP_W = 32;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/lab1_imul_rr_arb2.sv
// Two-way round-robin arbiter: pointer register plus combinational grant.
// The pointer only moves on an issue handshake, so the grant is stable while valids hold.
module lab1_imul_rr_arb2
    import lab1_imul_arb_pkg::*;
#(
    parameter logic p_init_prio = PORT0
) (
    input  logic clk,
    input  logic reset,
    input  logic req0_val,
    input  logic req1_val,
    input  logic issue,
    output logic gnt_val,
    output logic gnt_port
);

    logic ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= p_init_prio;
        end else if (issue) begin
            ptr_q <= ~gnt_port;
        end
    end

    always_comb begin
        gnt_val = req0_val | req1_val;
        if (req0_val && req1_val) begin
            gnt_port = ptr_q;
        end else if (req1_val) begin
            gnt_port = PORT1;
        end else begin
            gnt_port = PORT0;
        end
    end

endmodule

// File: rtl/lab1_imul_mul_arb2.sv
// Shares one variable-latency multiplier between two val/rdy requesters.
// Handshake: a transfer happens on a rising edge where val and rdy are both high; val never waits on rdy.
module lab1_imul_mul_arb2
    import lab1_imul_arb_pkg::*;
#(
    parameter logic p_init_prio = PORT0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_val,
    output logic              req0_rdy,
    input  logic [REQ_W-1:0]  req0_msg,
    input  logic              req1_val,
    output logic              req1_rdy,
    input  logic [REQ_W-1:0]  req1_msg,

    output logic              resp0_val,
    input  logic              resp0_rdy,
    output logic [RESP_W-1:0] resp0_msg,
    output logic              resp1_val,
    input  logic              resp1_rdy,
    output logic [RESP_W-1:0] resp1_msg,

    output logic              mul_req_val,
    input  logic              mul_req_rdy,
    output logic [REQ_W-1:0]  mul_req_msg,

    input  logic              mul_resp_val,
    output logic              mul_resp_rdy,
    input  logic [RESP_W-1:0] mul_resp_msg,

    output logic              busy,
    output logic              owner
);

    arb_state_e state_q, state_d;
    logic       owner_q;
    logic       arb_req0_val, arb_req1_val;
    logic       gnt_val, gnt_port;
    logic       issue, resp_done;

    // Requests only compete in IDLE and never while reset is held.
    assign arb_req0_val = (state_q == IDLE) && !reset && req0_val;
    assign arb_req1_val = (state_q == IDLE) && !reset && req1_val;
    assign issue        = gnt_val && mul_req_rdy;
    assign resp_done    = (state_q == BUSY) && mul_resp_val && mul_resp_rdy;

    lab1_imul_rr_arb2 #(
        .p_init_prio (p_init_prio)
    ) u_rr_arb (
        .clk      (clk),
        .reset    (reset),
        .req0_val (arb_req0_val),
        .req1_val (arb_req1_val),
        .issue    (issue),
        .gnt_val  (gnt_val),
        .gnt_port (gnt_port)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= PORT0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                owner_q <= gnt_port;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue)     state_d = BUSY;
            BUSY:    if (resp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_rdy     = 1'b0;
        req1_rdy     = 1'b0;
        mul_req_val  = 1'b0;
        mul_req_msg  = '0;
        resp0_val    = 1'b0;
        resp0_msg    = '0;
        resp1_val    = 1'b0;
        resp1_msg    = '0;
        mul_resp_rdy = 1'b0;
        busy         = 1'b0;
        owner        = PORT0;
        case (state_q)
            IDLE: begin
                mul_req_val = gnt_val;
                if (gnt_val) begin
                    if (gnt_port == PORT1) begin
                        mul_req_msg = req1_msg;
                        req1_rdy    = mul_req_rdy;
                    end else begin
                        mul_req_msg = req0_msg;
                        req0_rdy    = mul_req_rdy;
                    end
                end
            end
            BUSY: begin
                busy  = 1'b1;
                owner = owner_q;
                if (owner_q == PORT1) begin
                    resp1_val    = mul_resp_val;
                    resp1_msg    = mul_resp_msg;
                    mul_resp_rdy = resp1_rdy;
                end else begin
                    resp0_val    = mul_resp_val;
                    resp0_msg    = mul_resp_msg;
                    mul_resp_rdy = resp0_rdy;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lab1_imul_mul_arb2.sv
// Self-checking bench for lab1_imul_mul_arb2 with a behavioural multiplier and arbiter model.
module tb_lab1_imul_mul_arb2;
    import lab1_imul_arb_pkg::*;

    localparam logic P_INIT = PORT0;

    logic              clk;
    logic              reset;
    logic              req0_val, req0_rdy, req1_val, req1_rdy;
    logic [REQ_W-1:0]  req0_msg, req1_msg;
    logic              resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic [RESP_W-1:0] resp0_msg, resp1_msg;
    logic              mul_req_val, mul_req_rdy;
    logic [REQ_W-1:0]  mul_req_msg;
    logic              mul_resp_val, mul_resp_rdy;
    logic [RESP_W-1:0] mul_resp_msg;
    logic              busy, owner;

    lab1_imul_mul_arb2 #(.p_init_prio(P_INIT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_val     (req0_val),
        .req0_rdy     (req0_rdy),
        .req0_msg     (req0_msg),
        .req1_val     (req1_val),
        .req1_rdy     (req1_rdy),
        .req1_msg     (req1_msg),
        .resp0_val    (resp0_val),
        .resp0_rdy    (resp0_rdy),
        .resp0_msg    (resp0_msg),
        .resp1_val    (resp1_val),
        .resp1_rdy    (resp1_rdy),
        .resp1_msg    (resp1_msg),
        .mul_req_val  (mul_req_val),
        .mul_req_rdy  (mul_req_rdy),
        .mul_req_msg  (mul_req_msg),
        .mul_resp_val (mul_resp_val),
        .mul_resp_rdy (mul_resp_rdy),
        .mul_resp_msg (mul_resp_msg),
        .busy         (busy),
        .owner        (owner)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and model state
    int n_vec = 0;
    int n_err = 0;

    logic [REQ_W-1:0]  req_q[2][$];
    logic [RESP_W-1:0] exp_q[2][$];
    int   grant_log[$];
    int   resp_log[$];
    bit   mdl_busy;
    logic mdl_ptr, mdl_owner;

    bit                mul_busy;
    int                mul_cnt;
    logic [RESP_W-1:0] mul_prod;

    int acc_prob, lat_min, lat_max;
    int rdy_prob[2];
    int stall_left[2];
    int stall_seen, busy_cycles;
    bit b2b_mode;
    int cyc, last_resp_cyc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int grant_at(input int i);
        return (i < grant_log.size()) ? grant_log[i] : -1;
    endfunction

    function automatic int resp_at(input int i);
        return (i < resp_log.size()) ? resp_log[i] : -1;
    endfunction

    task automatic set_policy(input int acc, input int r0, input int r1, input int lmin, input int lmax);
        acc_prob    = acc;
        rdy_prob[0] = r0;
        rdy_prob[1] = r1;
        lat_min     = lmin;
        lat_max     = lmax;
    endtask

    // One clock cycle: drive at negedge, check settled outputs, advance the model for the next posedge.
    task automatic cycle();
        logic v0, v1, any, g, o;
        logic ov, or_, xv;
        logic [RESP_W-1:0] om, xm, a, b;
        @(negedge clk);
        cyc++;
        if (mul_busy && mul_cnt > 0) mul_cnt--;
        v0 = req_q[0].size() != 0;
        v1 = req_q[1].size() != 0;
        req0_val     = v0;
        req0_msg     = v0 ? req_q[0][0] : {$urandom, $urandom};
        req1_val     = v1;
        req1_msg     = v1 ? req_q[1][0] : {$urandom, $urandom};
        mul_req_rdy  = !mul_busy && ($urandom_range(99) < acc_prob);
        mul_resp_val = mul_busy && (mul_cnt == 0);
        mul_resp_msg = mul_busy ? mul_prod : $urandom;
        resp0_rdy    = (stall_left[0] == 0) && ($urandom_range(99) < rdy_prob[0]);
        resp1_rdy    = (stall_left[1] == 0) && ($urandom_range(99) < rdy_prob[1]);
        #1;
        if (!mdl_busy) begin
            any = v0 | v1;
            g   = (v0 && v1) ? mdl_ptr : v1;
            check_eq("idle_busy", busy, 0);
            check_eq("idle_owner", owner, 0);
            check_eq("idle_mul_resp_rdy", mul_resp_rdy, 0);
            check_eq("idle_resp_vals", {resp0_val, resp1_val}, 0);
            check_eq("idle_mul_req_val", mul_req_val, any);
            check_eq("idle_mul_req_msg", mul_req_msg, any ? req_q[g][0] : 64'd0);
            check_eq("idle_req0_rdy", req0_rdy, any && g == PORT0 && mul_req_rdy);
            check_eq("idle_req1_rdy", req1_rdy, any && g == PORT1 && mul_req_rdy);
            if (any && mul_req_rdy) begin
                if (b2b_mode && last_resp_cyc >= 0) check_eq("b2b_gap", cyc - last_resp_cyc, 1);
                {a, b} = req_q[g].pop_front();
                exp_q[g].push_back(a * b);
                grant_log.push_back(int'(g));
                mdl_ptr   = !g;
                mdl_owner = g;
                mdl_busy  = 1'b1;
                mul_busy  = 1'b1;
                mul_cnt   = $urandom_range(lat_max, lat_min);
                mul_prod  = a * b;
            end
        end else begin
            busy_cycles++;
            o   = mdl_owner;
            ov  = o ? resp1_val : resp0_val;
            om  = o ? resp1_msg : resp0_msg;
            or_ = o ? resp1_rdy : resp0_rdy;
            xv  = o ? resp0_val : resp1_val;
            xm  = o ? resp0_msg : resp1_msg;
            check_eq("busy_busy", busy, 1);
            check_eq("busy_owner", owner, mdl_owner);
            check_eq("busy_req_rdys", {req0_rdy, req1_rdy}, 0);
            check_eq("busy_mul_req_val", mul_req_val, 0);
            check_eq("busy_resp_val", ov, mul_resp_val);
            if (mul_resp_val) check_eq("busy_resp_msg", om, exp_q[o][0]);
            check_eq("busy_mul_resp_rdy", mul_resp_rdy, or_);
            check_eq("busy_other_resp", {xv, xm}, 0);
            if (mul_resp_val && or_) begin
                void'(exp_q[o].pop_front());
                resp_log.push_back(int'(o));
                mdl_busy      = 1'b0;
                mul_busy      = 1'b0;
                last_resp_cyc = cyc;
            end else if (mul_resp_val && stall_left[o] > 0) begin
                stall_left[o]--;
                stall_seen++;
            end
        end
    endtask

    // Asynchronous reset applied mid-cycle; the multiplier model is reset alongside.
    task automatic do_reset(input int n);
        @(negedge clk);
        #2;
        reset        = 1'b1;
        mul_req_rdy  = 1'b0;
        mul_resp_val = 1'b0;
        req0_val     = req_q[0].size() != 0;
        req1_val     = req_q[1].size() != 0;
        mdl_busy     = 1'b0;
        mdl_ptr      = P_INIT;
        mdl_owner    = PORT0;
        mul_busy     = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        stall_left[0] = 0;
        stall_left[1] = 0;
        #1;
        for (int i = 0; i < n; i++) begin
            check_eq("rst_outputs", {busy, owner, mul_req_val, req0_rdy, req1_rdy,
                                     resp0_val, resp1_val, mul_resp_rdy}, 0);
            @(negedge clk);
        end
        reset = 1'b0;
        grant_log.delete();
        resp_log.delete();
        busy_cycles   = 0;
        stall_seen    = 0;
        last_resp_cyc = -1;
    endtask

    task automatic run_until_idle(input int budget);
        int left;
        left = budget;
        while ((req_q[0].size() + req_q[1].size() != 0 || mdl_busy) && left > 0) begin
            cycle();
            left--;
        end
        check_eq("drain_timeout", req_q[0].size() + req_q[1].size() + int'(mdl_busy), 0);
    endtask

    task automatic wait_grants(input int n, input int budget);
        int left;
        left = budget;
        while (grant_log.size() < n && left > 0) begin
            cycle();
            left--;
        end
        check_eq("grant_timeout", grant_log.size() >= n, 1);
    endtask

    initial begin
        reset = 1'b0;
        {req0_val, req1_val, resp0_rdy, resp1_rdy, mul_req_rdy, mul_resp_val} = '0;
        req0_msg = '0;
        req1_msg = '0;
        mul_resp_msg = '0;
        b2b_mode = 1'b0;
        cyc = 0;
        set_policy(100, 100, 100, 1, 1);
        #1;
        do_reset(3);

        // Single transaction, 5-cycle multiplier
        set_policy(100, 100, 100, 5, 5);
        req_q[0].push_back({32'd3, 32'd4});
        run_until_idle(50);
        check_eq("single_nresp", resp_log.size(), 1);
        check_eq("single_port", resp_at(0), 0);
        check_eq("single_busy_ge5", busy_cycles >= 5, 1);

        // Contention right after reset
        do_reset(2);
        set_policy(100, 100, 100, 2, 4);
        req_q[0].push_back({32'd2, 32'd5});
        req_q[1].push_back({32'd7, 32'd6});
        run_until_idle(50);
        check_eq("cont_first", resp_at(0), 0);
        check_eq("cont_second", resp_at(1), 1);

        // Fairness: both hold val for six transactions
        do_reset(2);
        set_policy(100, 100, 100, 1, 4);
        for (int i = 0; i < 3; i++) begin
            req_q[0].push_back({$urandom, $urandom});
            req_q[1].push_back({$urandom, $urandom});
        end
        run_until_idle(200);
        for (int i = 0; i < 6; i++) check_eq("fair_grant", grant_at(i), i % 2);

        // Backpressure on port 1 for ten cycles while port 0 waits
        do_reset(2);
        set_policy(100, 100, 100, 2, 2);
        stall_left[1] = 10;
        req_q[1].push_back({$urandom, $urandom});
        wait_grants(1, 20);
        req_q[0].push_back({$urandom, $urandom});
        run_until_idle(100);
        check_eq("bp_stall_cycles", stall_seen, 10);
        check_eq("bp_order0", grant_at(0), 1);
        check_eq("bp_order1", grant_at(1), 0);

        // Reset while BUSY, then both valid
        do_reset(2);
        set_policy(100, 100, 100, 8, 8);
        req_q[0].push_back({$urandom, $urandom});
        wait_grants(1, 20);
        cycle();
        cycle();
        req_q[0].push_back({$urandom, $urandom});
        req_q[1].push_back({$urandom, $urandom});
        do_reset(2);
        set_policy(100, 100, 100, 1, 3);
        run_until_idle(100);
        check_eq("rst_next_grant", grant_at(0), P_INIT);
        check_eq("rst_then_other", grant_at(1), !P_INIT);

        // Back-to-back issues from one requester
        do_reset(2);
        set_policy(100, 100, 100, 1, 3);
        b2b_mode = 1'b1;
        for (int i = 0; i < 8; i++) req_q[0].push_back({$urandom, $urandom});
        run_until_idle(200);
        b2b_mode = 1'b0;
        check_eq("b2b_count", resp_log.size(), 8);

        // Randomized traffic
        do_reset(2);
        set_policy(70, 60, 60, 1, 6);
        for (int i = 0; i < 1500; i++) begin
            if (req_q[0].size() < 3 && $urandom_range(99) < 30) req_q[0].push_back({$urandom, $urandom});
            if (req_q[1].size() < 3 && $urandom_range(99) < 30) req_q[1].push_back({$urandom, $urandom});
            if (!mdl_busy && $urandom_range(99) < 5) stall_left[$urandom_range(1)] = $urandom_range(6);
            cycle();
        end
        run_until_idle(500);
        check_eq("rand_exp_empty", exp_q[0].size() + exp_q[1].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lab1_imul_mul_arb2.md
LAB1_IMUL_MUL_ARB2 -- requirements
Module: lab1_imul_mul_arb2

Interface
REQ-001 SHALL have parameter: p_init_prio, 0, port favoured by the round-robin pointer after reset (0 or 1).
REQ-002 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: req0_val/req1_val  in  1  requester request valid.
REQ-005 SHALL have ports: req0_rdy/req1_rdy  out  1  requester request ready.
REQ-006 SHALL have ports: req0_msg/req1_msg  in  64  operands {a[63:32], b[31:0]}.
REQ-007 SHALL have ports: resp0_val/resp1_val  out  1; resp0_rdy/resp1_rdy  in  1; resp0_msg/resp1_msg  out  32  product.
REQ-008 SHALL have ports: mul_req_val  out  1; mul_req_rdy  in  1; mul_req_msg  out  64  to the shared variable-latency multiplier.
REQ-009 SHALL have ports: mul_resp_val  in  1; mul_resp_rdy  out  1; mul_resp_msg  in  32  from the multiplier.
REQ-010 SHALL have ports: busy  out  1  transaction outstanding; owner  out  1  port id of outstanding transaction.

Function
REQ-011 SHALL share one multiplier between two val/rdy requesters, with at most one transaction outstanding.
REQ-012 SHALL implement FSM states IDLE and BUSY; IDLE->BUSY on mul request handshake; BUSY->IDLE on granted response handshake; no other transitions.
REQ-013 In IDLE, grant SHALL go to the only valid requester, or to the pointer port if both valid; none if neither.
REQ-014 In IDLE, mul_req_val SHALL equal granted reqN_val, mul_req_msg SHALL equal granted reqN_msg (0 if no grant), granted reqN_rdy SHALL equal mul_req_rdy; non-granted req rdy = 0.
REQ-015 On issue handshake, owner SHALL latch the granted port and pointer SHALL become the other port; pointer SHALL not change otherwise.
REQ-016 In BUSY, both reqN_rdy = 0 and mul_req_val = 0.
REQ-017 In BUSY, resp<owner>_val = mul_resp_val, resp<owner>_msg = mul_resp_msg, mul_resp_rdy = resp<owner>_rdy; other port resp_val = 0, resp_msg = 0.
REQ-018 In IDLE, mul_resp_rdy = 0 and both resp_val = 0.
REQ-019 Arbiter SHALL add zero cycles of latency on both paths (combinational pass-through); next issue earliest the cycle after a response handshake.
REQ-020 Response backpressure SHALL hold BUSY indefinitely, msg unchanged, with no loss.
REQ-021 Grant SHALL be stable while in IDLE with unchanged valids; a requester holding val SHALL be served within two transactions (starvation-free).
REQ-022 busy SHALL be 1 exactly in BUSY; owner SHALL be latched value in BUSY, 0 in IDLE.

Reset
REQ-023 Reset SHALL force IDLE, pointer = p_init_prio, owner = 0, asynchronously, including mid-transaction.
REQ-024 During and after reset, all val/rdy outputs SHALL be 0 until IDLE grant logic acts; busy = 0.
REQ-025 The multiplier SHALL share the same reset so no stale response survives.

Structure
REQ-026 Package lab1_imul_arb_pkg SHALL hold the state typedef (IDLE, BUSY) and port-id constants PORT0/PORT1.
REQ-027 Sub-module lab1_imul_rr_arb2 SHALL contain pointer register and grant logic; FSM and muxing stay in top.

Verification
REQ-028 Single: req0 a=3,b=4, multiplier takes 5 cycles -> resp0_msg=12, resp1_val never 1, busy high 5+ cycles.
REQ-029 Contention: both valid after reset (p_init_prio=0), req0 2x5, req1 7x6 -> resp0=10 first, then resp1=42.
REQ-030 Fairness: both hold val for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-031 Backpressure: resp1_rdy=0 for 10 cycles after resp1_val -> msg stable, req0 not granted until handshake.
REQ-032 Reset mid-BUSY (req0 issued, reset at cycle 2) -> busy=0, all val 0 immediately; next grant follows p_init_prio.
REQ-033 Back-to-back: req0 always valid, resp0_rdy=1 -> new issue exactly one cycle after each response handshake.
